// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
//   Multi-cycle control sequencer for the CPU. It walks each instruction
//   through FETCH / DECODE / execute / memory / writeback states. From the
//   current state, the latched opcode and the ready/zero inputs it drives the
//   datapath strobes.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   opcode       opcode field from IR (sampled only in DECODE)
//   zero_flag    ALU result == 0
//   instr_ready  instruction ROM data valid this cycle
//   mem_ready    data memory access complete this cycle
//   pc_writ      PC load enable
//   pc_src       0 = pc+2, 1 = pc+imm
//   ir_writ      IR load enable
//   reg_writ     register-file write enable
//   reg_dst      0 = rd, 1 = rs2 as destination
//   alu_src      0 = reg_dat2, 1 = imm_extend
//   alu_op       ALU function (ADD=0, SUB=1, AND=2, OR=3)
//   mem_read     data memory read request
//   mem_write    data memory write request
//   mem_to_reg   writeback source = memory
//   halted       sequencer parked in HALT
//   trap         sequencer parked in TRAP (illegal opcode)
//   retired      count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module mc_sequencer #(
    parameter int OPC_W    = 4,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                zero_flag,
    input  logic                instr_ready,
    input  logic                mem_ready,
    output logic                pc_writ,
    output logic                pc_src,
    output logic                ir_writ,
    output logic                reg_writ,
    output logic                reg_dst,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                halted,
    output logic                trap,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_ALU_WB   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_HALT     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd12;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2'd0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(2'd1);

    logic [3:0]       state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_s;

    // Opcodes wider than the 4-bit encoding space are only legal when every
    // bit above bit 3 is zero.
    function automatic logic opc_in_range(input logic [OPC_W-1:0] opc);
        return ((opc >> 3'd4) == {OPC_W{1'b0}});
    endfunction

    // State, latched opcode and retired counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= 4'd0;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic; opcode is captured only while in DECODE so later IR
    // changes cannot disturb an instruction in flight.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        retire_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (instr_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d = opcode[3:0];
                if (!opc_in_range(opcode)) begin
                    state_d = S_TRAP;
                end else begin
                    case (opcode[3:0])
                        OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_R;
                        OP_ADDI:                       state_d = S_EXEC_I;
                        OP_LW, OP_SW:                  state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:                state_d = S_BRANCH;
                        OP_JMP:                        state_d = S_JUMP;
                        OP_HALT:                       state_d = S_HALT;
                        default:                       state_d = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R:   state_d = S_ALU_WB;
            S_EXEC_I:   state_d = S_ALU_WB;
            S_ALU_WB: begin
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_ADDR: begin
                if (op_q == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_BRANCH: begin
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Retired counter wraps naturally at 2**CNT_W.
    always_comb begin
        if (retire_s) begin
            retired_d = retired_q + CNT_W'(1'b1);
        end else begin
            retired_d = retired_q;
        end
    end

    assign retired = retired_q;

    // Output decode. Outputs are combinational from state, so the reset
    // input masks them directly; no strobe may glitch high while reset is held.
    always_comb begin
        pc_writ    = 1'b0;
        pc_src     = 1'b0;
        ir_writ    = 1'b0;
        reg_writ   = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (instr_ready) begin
                    ir_writ = 1'b1;
                    pc_writ = 1'b1;
                end else begin
                    ir_writ = 1'b0;
                    pc_writ = 1'b0;
                end
            end
            S_DECODE: begin
                ir_writ = 1'b0;
            end
            S_EXEC_R: begin
                alu_op = ALU_OP_W'(op_q[1:0]);
            end
            S_EXEC_I: begin
                alu_src = 1'b1;
            end
            S_ALU_WB: begin
                reg_writ = 1'b1;
                // Keep the ALU configured as in the preceding EXEC state so the
                // result stays stable through the register write.
                if (op_q == OP_ADDI) begin
                    reg_dst = 1'b1;
                    alu_src = 1'b1;
                end else begin
                    alu_op = ALU_OP_W'(op_q[1:0]);
                end
            end
            S_MEM_ADDR: begin
                alu_src = 1'b1;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
            end
            S_MEM_WB: begin
                reg_writ   = 1'b1;
                mem_to_reg = 1'b1;
                reg_dst    = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
            end
            S_BRANCH: begin
                alu_op = ALU_SUB;
                pc_src = 1'b1;
                if (op_q == OP_BNE) begin
                    pc_writ = !zero_flag;
                end else begin
                    pc_writ = zero_flag;
                end
            end
            S_JUMP: begin
                pc_writ = 1'b1;
                pc_src  = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            S_TRAP:  trap   = 1'b1;
            default: trap   = 1'b0;
        endcase
        if (reset) begin
            pc_writ    = 1'b0;
            pc_src     = 1'b0;
            ir_writ    = 1'b0;
            reg_writ   = 1'b0;
            reg_dst    = 1'b0;
            alu_src    = 1'b0;
            alu_op     = ALU_ADD;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
            trap       = 1'b0;
        end else begin
            halted = halted;
        end
    end

endmodule
